// File: rtl/mux_pkg.sv
// Shared definitions for the N-to-1 streaming multiplexer.
package mux_pkg;

   localparam int N_DEF     = 4;
   localparam int WIDTH_DEF = 8;

   // Index width for n items, never less than one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/mux_n_x_1_stream_rr_arbiter.sv
// Round-robin arbiter for mux_n_x_1_stream. The module is only defined when
// MUX_RR_EN is set, so explicit-select builds carry no pointer or search logic.
`ifdef MUX_RR_EN
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int N    = N_DEF,
   parameter int SELW = clog2_min1(N_DEF)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic            advance,
   output logic [SELW-1:0] grant_idx,
   output logic            grant_vld
);

   logic [SELW-1:0] ptr_q, ptr_d;
   int              scan_idx;

   // First requester at or above ptr, wrapping past N-1 back to 0.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_idx  = 0;
      for (int k = 0; k < N; k++) begin
         scan_idx = int'(ptr_q) + k;
         if (scan_idx >= N) scan_idx = scan_idx - N;
         if (!grant_vld && req[scan_idx]) begin
            grant_vld = 1'b1;
            grant_idx = SELW'(scan_idx);
         end
      end
   end

   // Pointer moves past the winner only when a word is actually taken.
   always_comb begin
      ptr_d = ptr_q;
      if (advance) ptr_d = SELW'((int'(grant_idx) + 1) % N);
   end

   // Pointer register.
   always_ff @(posedge clk) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule
`endif

// File: rtl/mux_n_x_1_stream.sv
// N-to-1 valid/ready multiplexer with a one-entry registered output tagged by
// source channel. Build option MUX_RR_EN: round-robin arbitration across the
// valid inputs replaces the explicit sel input.
//
// state | meaning
// EMPTY | out_valid=0, register free, a chosen channel may load
// FULL  | out_valid=1, word held until out_ready; reload allowed same cycle
module mux_n_x_1_stream
   import mux_pkg::*;
#(
   parameter int   N     = N_DEF,
   parameter int   WIDTH = WIDTH_DEF,
   localparam int  SELW  = clog2_min1(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SELW-1:0]    sel,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SELW-1:0]    out_chan
);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_chan_q, out_chan_d;
   logic             out_valid_q, out_valid_d;

   logic [SELW-1:0]  chosen;
   logic             chosen_ok;
   logic             can_load;
   logic             xfer_in;
   logic [WIDTH-1:0] chosen_data;

`ifdef MUX_RR_EN
   rr_arbiter #(
      .N    (N),
      .SELW (SELW)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (in_valid),
      .advance   (xfer_in),
      .grant_idx (chosen),
      .grant_vld (chosen_ok)
   );
`else
   assign chosen    = sel;
   assign chosen_ok = (int'(sel) < N);
`endif

   assign can_load = !out_valid_q || out_ready;

   // Only the chosen channel sees ready, and only when the register can take a word.
   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
`ifdef MUX_RR_EN
         in_ready[i] = can_load && chosen_ok && (int'(chosen) == i) && in_valid[i];
`else
         in_ready[i] = can_load && chosen_ok && (int'(chosen) == i);
`endif
      end
   end

   assign xfer_in = |(in_ready & in_valid);

   // Data mux by loop so an out-of-range index never slices outside in_data.
   always_comb begin
      chosen_data = '0;
      for (int i = 0; i < N; i++) begin
         if (int'(chosen) == i) chosen_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   // Next output-register contents: load on transfer in, drain on transfer out.
   always_comb begin
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_valid_d = out_valid_q;
      if (xfer_in) begin
         out_data_d  = chosen_data;
         out_chan_d  = chosen;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Output register; reset discards any held word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_n_x_1_stream.sv
// Directed bench for mux_n_x_1_stream: a 4-channel instance for the main
// sequences and a 3-channel instance for the out-of-range select case.
module tb_mux_n_x_1_stream;

   logic        clk;
   logic        rst_n;

   logic [31:0] in_data_a;
   logic [3:0]  in_valid_a;
   logic [3:0]  in_ready_a;
   logic [1:0]  sel_a;
   logic [7:0]  out_data_a;
   logic        out_valid_a;
   logic        out_ready_a;
   logic [1:0]  out_chan_a;

   logic [23:0] in_data_b;
   logic [2:0]  in_valid_b;
   logic [2:0]  in_ready_b;
   logic [1:0]  sel_b;
   logic [7:0]  out_data_b;
   logic        out_valid_b;
   logic        out_ready_b;
   logic [1:0]  out_chan_b;

   int checks = 0;
   int errors = 0;

   mux_n_x_1_stream #(.N(4), .WIDTH(8)) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data_a),
      .in_valid  (in_valid_a),
      .in_ready  (in_ready_a),
      .sel       (sel_a),
      .out_data  (out_data_a),
      .out_valid (out_valid_a),
      .out_ready (out_ready_a),
      .out_chan  (out_chan_a)
   );

   mux_n_x_1_stream #(.N(3), .WIDTH(8)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data_b),
      .in_valid  (in_valid_b),
      .in_ready  (in_ready_b),
      .sel       (sel_b),
      .out_data  (out_data_b),
      .out_valid (out_valid_b),
      .out_ready (out_ready_b),
      .out_chan  (out_chan_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch_a(input int ch, input logic [7:0] v);
      in_data_a[ch*8 +: 8] = v;
   endtask

   initial begin
      rst_n       = 1'b0;
      in_data_a   = {8'h40, 8'h30, 8'h20, 8'h10};
      in_valid_a  = 4'b0000;
      sel_a       = 2'd0;
      out_ready_a = 1'b0;
      in_data_b   = {8'h33, 8'h22, 8'h11};
      in_valid_b  = 3'b000;
      sel_b       = 2'd0;
      out_ready_b = 1'b0;

      step();
      step();
      rst_n = 1'b1;
      #1;
      chk("reset_out_valid", out_valid_a, 0);
      chk("reset_out_data",  out_data_a, 0);
      chk("reset_out_chan",  out_chan_a, 0);

`ifndef MUX_RR_EN
      // Empty register: ready is live for sel even with out_ready low.
      chk("reset_in_ready", in_ready_a, 4'b0001);

      sel_a       = 2'd2;
      in_valid_a  = 4'b1111;
      out_ready_a = 1'b1;
      #1;
      chk("sel2_in_ready", in_ready_a, 4'b0100);
      step();
      chk("sel2_valid", out_valid_a, 1);
      chk("sel2_data",  out_data_a, 8'h30);
      chk("sel2_chan",  out_chan_a, 2);

      // Backpressure: next word on ch2 is 0x33, held off for 5 cycles.
      out_ready_a = 1'b0;
      set_ch_a(2, 8'h33);
      #1;
      chk("bp_in_ready0", in_ready_a, 4'b0000);
      for (int k = 0; k < 5; k++) begin
         sel_a = 2'(k);
         #1;
         chk("bp_in_ready", in_ready_a, 4'b0000);
         step();
         chk("bp_valid", out_valid_a, 1);
         chk("bp_data",  out_data_a, 8'h30);
         chk("bp_chan",  out_chan_a, 2);
      end

      sel_a       = 2'd2;
      out_ready_a = 1'b1;
      #1;
      chk("release_in_ready", in_ready_a, 4'b0100);
      step();
      chk("release_valid", out_valid_a, 1);
      chk("release_data",  out_data_a, 8'h33);
      chk("release_chan",  out_chan_a, 2);

      // Back-to-back from another channel, no bubble.
      sel_a = 2'd1;
      step();
      chk("b2b_valid", out_valid_a, 1);
      chk("b2b_data",  out_data_a, 8'h20);
      chk("b2b_chan",  out_chan_a, 1);

      sel_a = 2'd3;
      step();
      chk("b2b3_data", out_data_a, 8'h40);
      chk("b2b3_chan", out_chan_a, 3);

      // Drain with nothing offered.
      in_valid_a = 4'b0000;
      step();
      chk("drain_valid", out_valid_a, 0);
      chk("drain_data_held", out_data_a, 8'h40);

      // Load from channel 0, then reset while FULL.
      in_valid_a = 4'b0001;
      sel_a      = 2'd0;
      step();
      chk("ch0_valid", out_valid_a, 1);
      chk("ch0_data",  out_data_a, 8'h10);
      chk("ch0_chan",  out_chan_a, 0);
      out_ready_a = 1'b0;
      in_valid_a  = 4'b0000;
      rst_n       = 1'b0;
      step();
      chk("midrst_valid", out_valid_a, 0);
      chk("midrst_data",  out_data_a, 0);
      chk("midrst_chan",  out_chan_a, 0);
      rst_n = 1'b1;

      // N=3: sel=3 selects nothing.
      sel_b       = 2'd3;
      in_valid_b  = 3'b111;
      out_ready_b = 1'b1;
      #1;
      chk("oor_in_ready", in_ready_b, 3'b000);
      step();
      chk("oor_valid1", out_valid_b, 0);
      step();
      chk("oor_valid2", out_valid_b, 0);
      chk("oor_in_ready2", in_ready_b, 3'b000);
      sel_b = 2'd2;
      #1;
      chk("n3_sel2_in_ready", in_ready_b, 3'b100);
      step();
      chk("n3_sel2_valid", out_valid_b, 1);
      chk("n3_sel2_data",  out_data_b, 8'h33);
      chk("n3_sel2_chan",  out_chan_b, 2);
`else
      // No valid input: nothing is ready.
      chk("rr_idle_in_ready", in_ready_a, 4'b0000);

      in_valid_a  = 4'b1011;
      out_ready_a = 1'b1;
      #1;
      chk("rr_first_in_ready", in_ready_a, 4'b0001);
      step();
      chk("rr_first_data", out_data_a, 8'h10);
      chk("rr_c0", out_chan_a, 0);
      step(); chk("rr_c1", out_chan_a, 1);
      chk("rr_c1_data", out_data_a, 8'h20);
      step(); chk("rr_c2", out_chan_a, 3);
      chk("rr_c2_data", out_data_a, 8'h40);
      step(); chk("rr_c3", out_chan_a, 0);
      step(); chk("rr_c4", out_chan_a, 1);
      step(); chk("rr_c5", out_chan_a, 3);
      chk("rr_c5_valid", out_valid_a, 1);

      // Channel 1 drops: pointer at 0 gives 0, then 3 (skipping 1), then 0.
      in_valid_a = 4'b1001;
      step(); chk("rr_drop_c0", out_chan_a, 0);
      step(); chk("rr_drop_c1", out_chan_a, 3);
      chk("rr_drop_valid", out_valid_a, 1);
      step(); chk("rr_drop_c2", out_chan_a, 0);

      // Pointer now 1; with 1101 it would grant 2, after reset it must grant 0.
      out_ready_a = 1'b0;
      in_valid_a  = 4'b1101;
      rst_n       = 1'b0;
      step();
      chk("rr_midrst_valid", out_valid_a, 0);
      chk("rr_midrst_chan",  out_chan_a, 0);
      rst_n       = 1'b1;
      out_ready_a = 1'b1;
      #1;
      chk("rr_after_rst_in_ready", in_ready_a, 4'b0001);
      step();
      chk("rr_after_rst_chan", out_chan_a, 0);
      chk("rr_after_rst_data", out_data_a, 8'h10);
      step();
      chk("rr_after_rst_next", out_chan_a, 2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
